vopbuf_collector: RTL
=====================

VOPBUF_COLLECTOR -- requirements
Module: vopbuf_collector

Interface
REQ-001 SHALL provide parameter NUM_ENTRIES, default 4, buffer depth (power of two, >=2).
REQ-002 SHALL provide parameter NUM_OPS, default 3, operand slots per entry (vs1, vs2, vs3/mask).
REQ-003 SHALL provide parameter NUM_ELEMENTS, default 32, elements per operand vector.
REQ-004 SHALL provide parameter ELEM_W, default 16, bits per element.
REQ-005 SHALL provide parameter META_W, default 32, bits of per-instruction sideband (opcode, vd, dtype).
REQ-006 SHALL derive TAG_W = clog2(NUM_ENTRIES) and VEC_W = NUM_ELEMENTS*ELEM_W.
REQ-007 SHALL provide port CLK, input, 1, single clock; all state on rising edge.
REQ-008 SHALL provide port nRST, input, 1, asynchronous active-high reset.
REQ-009 SHALL provide ports alloc_valid (input, 1), alloc_ready (output, 1), alloc_need (input, NUM_OPS), alloc_meta (input, META_W), alloc_tag (output, TAG_W); alloc_tag is the entry index granted on an accepted allocation.
REQ-010 SHALL provide ports wr_valid (input, NUM_OPS), wr_tag (input, NUM_OPS*TAG_W), wr_data (input, NUM_OPS*VEC_W); port k writes operand slot k of entry wr_tag[k].
REQ-011 SHALL provide ports out_valid (output, 1), out_ready (input, 1), out_meta (output, META_W), out_need (output, NUM_OPS), out_data (output, NUM_OPS*VEC_W).
REQ-012 SHALL provide ports count (output, clog2(NUM_ENTRIES+1)), occupied entries; err (output, 1), sticky protocol error.

Function
REQ-013 Each entry SHALL be in exactly one state: FREE, WAIT (operands outstanding), or RDY (all needed operands captured).
REQ-014 Allocation SHALL occur when alloc_valid && alloc_ready: tail entry takes alloc_need/alloc_meta, clears captured bits, and goes FREE->WAIT, or FREE->RDY if alloc_need==0; tail increments modulo NUM_ENTRIES.
REQ-015 alloc_tag SHALL equal the tail index combinationally; alloc_ready SHALL be !full from registered state; an entry freed in the same cycle SHALL NOT make alloc_ready high that cycle.
REQ-016 A write on port k to a WAIT entry whose need[k]=1 and captured[k]=0 SHALL capture wr_data[k] and set captured[k]; when captured==need the entry SHALL be RDY the next cycle.
REQ-017 Writes on different ports to the same entry in one cycle SHALL all be captured.
REQ-018 out_valid SHALL be high iff the head entry is RDY (registered state; minimum one cycle from last operand capture to out_valid).
REQ-019 Dispatch SHALL occur when out_valid && out_ready: head goes to FREE, head increments modulo NUM_ENTRIES; dispatch is strictly in allocation order.
REQ-020 out_data slot k SHALL be zero when out_need[k]=0; out_data/out_meta SHALL hold stable while out_valid && !out_ready.
REQ-021 count SHALL increment on allocation, decrement on dispatch, and be unchanged on both in one cycle; range 0..NUM_ENTRIES.
REQ-022 Pointers SHALL carry one extra wrap bit; full = (pointers equal and wrap bits differ), empty = equal including wrap bit.
REQ-023 err SHALL set and the write SHALL be dropped for: write to a FREE or RDY entry, write to a slot with need[k]=0, duplicate write to a captured slot, write to the entry being dispatched that cycle.
REQ-024 Allocation when alloc_ready=0 SHALL be ignored without error.

Reset
REQ-025 While nRST=1, all entries SHALL be FREE, head=tail=0, count=0, out_valid=0, alloc_ready=0, err=0, out_data=0, out_meta=0; alloc_ready SHALL be 1 in the first cycle after deassertion.
REQ-026 Reset asserted mid-operation SHALL discard all entries immediately and asynchronously; in-flight writes are lost without error.

Configuration
REQ-027 Macro VOPBUF_ALLOC_WR_EN defined: a write tagged with alloc_tag in the same cycle as that entry's allocation SHALL be captured against the new alloc_need.
REQ-028 Macro VOPBUF_ALLOC_WR_EN undefined: such a write SHALL be dropped and SHALL set err (entry still FREE that cycle).

Verification
REQ-029 Alloc need=3'b011 tag0, write port0 then port1 on separate cycles, out_ready=1 -> out_valid one cycle after port1 write, slot2 data zero, count 1->0.
REQ-030 Four allocs with no writes (NUM_ENTRIES=4) -> alloc_ready=0, count=4; fifth alloc ignored, err=0.
REQ-031 Fill entries 0,1; complete entry 1 first -> out_valid stays 0 until entry 0 completes; dispatch order 0 then 1.
REQ-032 Full buffer, dispatch with simultaneous alloc_valid -> no allocation that cycle; alloc accepted next cycle with alloc_tag=0 (wrap).
REQ-033 Write to slot with need=0, and duplicate write -> err=1 sticky, captured data unchanged.
REQ-034 Alloc tag0 need=3'b001 with same-cycle port0 write -> with VOPBUF_ALLOC_WR_EN out_valid next cycle; without it err=1 and entry remains WAIT.

Source files
------------

// File: rtl/vopbuf_collector.sv
// rtl/vopbuf_collector.sv - in-order vector operand collector; VOPBUF_ALLOC_WR_EN lets a write land on an entry in its allocation cycle
module vopbuf_collector #(
  parameter int NUM_ENTRIES  = 4,
  parameter int NUM_OPS      = 3,
  parameter int NUM_ELEMENTS = 32,
  parameter int ELEM_W       = 16,
  parameter int META_W       = 32,
  localparam int TAG_W       = $clog2(NUM_ENTRIES),
  localparam int VEC_W       = NUM_ELEMENTS * ELEM_W,
  localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [NUM_OPS-1:0]         alloc_need,
  input  logic [META_W-1:0]          alloc_meta,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_OPS-1:0]         wr_valid,
  input  logic [NUM_OPS*TAG_W-1:0]   wr_tag,
  input  logic [NUM_OPS*VEC_W-1:0]   wr_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [META_W-1:0]          out_meta,
  output logic [NUM_OPS-1:0]         out_need,
  output logic [NUM_OPS*VEC_W-1:0]   out_data,
  output logic [CNT_W-1:0]           count,
  output logic                       err
);

  typedef enum logic [1:0] {E_FREE, E_WAIT, E_RDY} ent_st_t;

  ent_st_t            st       [NUM_ENTRIES];
  ent_st_t            st_nxt   [NUM_ENTRIES];
  logic [NUM_OPS-1:0] need     [NUM_ENTRIES];
  logic [NUM_OPS-1:0] need_nxt [NUM_ENTRIES];
  logic [NUM_OPS-1:0] cap      [NUM_ENTRIES];
  logic [NUM_OPS-1:0] cap_nxt  [NUM_ENTRIES];
  logic [META_W-1:0]  meta     [NUM_ENTRIES];
  logic [VEC_W-1:0]   data     [NUM_ENTRIES][NUM_OPS];

  logic [TAG_W:0]     head, tail;
  logic [TAG_W-1:0]   head_idx, tail_idx;
  logic [TAG_W-1:0]   wr_idx   [NUM_OPS];
  logic [NUM_OPS-1:0] wr_ok;
  logic               full, empty, alloc_fire, disp_fire, wr_err;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign empty       = (head == tail);
  // Reset term keeps alloc_ready low while reset is held.
  assign alloc_ready = !nRST && !full;
  assign alloc_tag   = tail_idx;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign out_valid   = !empty && (st[head_idx] == E_RDY);
  assign disp_fire   = out_valid && out_ready;

  // Write legality: only outstanding, needed, not-yet-captured slots accept data.
  always_comb begin
    wr_ok  = '0;
    wr_err = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      wr_idx[k] = wr_tag[k*TAG_W +: TAG_W];
      if (wr_valid[k]) begin
        if (st[wr_idx[k]] == E_WAIT && need[wr_idx[k]][k] && !cap[wr_idx[k]][k] &&
            !(disp_fire && wr_idx[k] == head_idx))
          wr_ok[k] = 1'b1;
`ifdef VOPBUF_ALLOC_WR_EN
        else if (alloc_fire && wr_idx[k] == tail_idx && alloc_need[k])
          wr_ok[k] = 1'b1;
`endif
        else
          wr_err = 1'b1;
      end
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      st_nxt[e]   = st[e];
      need_nxt[e] = need[e];
      cap_nxt[e]  = cap[e];
      if (alloc_fire && tail_idx == TAG_W'(e)) begin
        need_nxt[e] = alloc_need;
        cap_nxt[e]  = '0;
        st_nxt[e]   = E_WAIT;
      end
      if (disp_fire && head_idx == TAG_W'(e))
        st_nxt[e] = E_FREE;
      for (int k = 0; k < NUM_OPS; k++)
        if (wr_ok[k] && wr_idx[k] == TAG_W'(e))
          cap_nxt[e][k] = 1'b1;
      if (st_nxt[e] == E_WAIT && cap_nxt[e] == need_nxt[e])
        st_nxt[e] = E_RDY;
    end
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        st[e]   <= E_FREE;
        need[e] <= '0;
        cap[e]  <= '0;
        meta[e] <= '0;
      end
    end else begin
      if (alloc_fire) begin
        tail           <= tail + 1'b1;
        meta[tail_idx] <= alloc_meta;
      end
      if (disp_fire)
        head <= head + 1'b1;
      if (alloc_fire && !disp_fire)
        count <= count + 1'b1;
      else if (disp_fire && !alloc_fire)
        count <= count - 1'b1;
      if (wr_err)
        err <= 1'b1;
      for (int e = 0; e < NUM_ENTRIES; e++) begin
        st[e]   <= st_nxt[e];
        need[e] <= need_nxt[e];
        cap[e]  <= cap_nxt[e];
      end
    end
  end

  // Payload needs no reset: it is only visible once its slot has been captured.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_OPS; k++)
      if (wr_ok[k])
        data[wr_idx[k]][k] <= wr_data[k*VEC_W +: VEC_W];
  end

  always_comb begin
    out_meta = '0;
    out_need = '0;
    out_data = '0;
    if (out_valid) begin
      out_meta = meta[head_idx];
      out_need = need[head_idx];
      for (int k = 0; k < NUM_OPS; k++)
        if (need[head_idx][k])
          out_data[k*VEC_W +: VEC_W] = data[head_idx][k];
    end
  end

endmodule
